uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_sync.sv | 58 +++++
 rtl/uart_rx_param.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// rx FSM encoding, baud timing derivation and configuration legality.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned calc_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Mid-bit point used as the centre of the 3-point vote.
  function automatic int unsigned calc_half(input int unsigned baud_div);
    return baud_div / 2;
  endfunction

  // Legal configuration ranges for the receiver.
  function automatic bit cfg_ok(input int unsigned data_bits,
                                input int unsigned parity_mode,
                                input int unsigned stop_bits,
                                input int unsigned baud_div,
                                input int unsigned sync_stages);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (parity_mode <= 2) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (baud_div >= 8) &&
           (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx synchroniser chain, falling-edge detector and start arming flag.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic clr_arm,
  output logic rxs,
  output logic fall,
  output logic armed
);

  // Counts edges until the chain holds real line samples instead of reset ones.
  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic                   filled;

  assign filled = (fill_q == FILL_W'(SYNC_STAGES));
  assign rxs    = sync_q[SYNC_STAGES-1];
  assign fall   = edge_q & ~sync_q[SYNC_STAGES-1];
  assign armed  = armed_q;

  // Next values: shift the line in, remember last rxs, arm once a real high is seen.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
    edge_d  = sync_q[SYNC_STAGES-1];
    fill_d  = filled ? fill_q : fill_q + FILL_W'(1);
    armed_d = armed_q;
    if (clr_arm) begin
      armed_d = 1'b0;
    end else if (filled && sync_q[SYNC_STAGES-1]) begin
      armed_d = 1'b1;
    end
  end

  // Synchroniser registers; the chain resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      edge_q  <= 1'b1;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-point majority sampling, parity/framing
// error and break detection, and a valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 rx_busy
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ_HZ, BAUD);
  localparam int unsigned HALF     = calc_half(BAUD_DIV);
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);

  if (!cfg_ok(DATA_BITS, PARITY_MODE, STOP_BITS, BAUD_DIV, SYNC_STAGES)) begin : g_cfg_err
    $error("uart_rx_param: illegal configuration");
  end

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_vote_q, par_vote_d;
  logic                 stop0_q, stop0_d;
  logic                 p_err_q, p_err_d;
  logic                 f_err_q, f_err_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 break_det_q, break_det_d;
  logic                 rx_busy_q, rx_busy_d;

  logic rxs, fall, armed, clr_arm;
  logic at_s0, at_s1, at_vote, at_end;
  logic vote, exp_par, last_data, last_stop;
  logic brk_stop0, is_break, frame_done, load;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .clr_arm(clr_arm),
    .rxs    (rxs),
    .fall   (fall),
    .armed  (armed)
  );

  assign at_s0      = (cnt_q == CNT_W'(HALF - 1));
  assign at_s1      = (cnt_q == CNT_W'(HALF));
  assign at_vote    = (cnt_q == CNT_W'(HALF + 1));
  assign at_end     = (cnt_q == CNT_W'(BAUD_DIV - 1));
  assign vote       = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign exp_par    = (PARITY_MODE == PARITY_ODD) ? ~(^data_q) : ^data_q;
  assign last_data  = (idx_q == IDX_W'(DATA_BITS - 1));
  assign last_stop  = (idx_q == IDX_W'(STOP_BITS - 1));
  assign brk_stop0  = (idx_q == '0) ? ~vote : stop0_q;
  assign is_break   = (data_q == '0) &&
                      ((PARITY_MODE == PARITY_NONE) || !par_vote_q) && brk_stop0;
  assign frame_done = (state_q == ST_STOP) && at_vote && last_stop;

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_det_q;
  assign rx_busy    = rx_busy_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (fall && armed) state_d = ST_START;
      ST_START: begin
        if (at_vote && vote)  state_d = ST_IDLE;
        else if (at_end)      state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_end && last_data) begin
          state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY:   if (at_end) state_d = ST_STOP;
      ST_STOP:     if (frame_done) state_d = is_break ? ST_BRK_WAIT : ST_IDLE;
      ST_BRK_WAIT: if (rxs) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Bit timing, sampling, frame assembly and holding-register outputs.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    data_d       = data_q;
    par_vote_d   = par_vote_q;
    stop0_d      = stop0_q;
    p_err_d      = p_err_q;
    f_err_d      = f_err_q;
    done_d       = 1'b0;
    break_det_d  = 1'b0;
    rx_busy_d    = (state_d != ST_IDLE);
    clr_arm      = (state_d == ST_BRK_WAIT) && (state_q != ST_BRK_WAIT);

    if ((state_q == ST_IDLE) || (state_q == ST_BRK_WAIT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
      if (at_s0) s0_d = rxs;
      if (at_s1) s1_d = rxs;
    end

    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_START) begin
          idx_d      = '0;
          data_d     = '0;
          par_vote_d = 1'b0;
          stop0_d    = 1'b0;
          p_err_d    = 1'b0;
          f_err_d    = 1'b0;
        end
      end
      ST_DATA: begin
        if (at_vote) data_d[idx_q] = vote;
        if (at_end)  idx_d = last_data ? '0 : idx_q + IDX_W'(1);
      end
      ST_PARITY: begin
        if (at_vote) begin
          par_vote_d = vote;
          if (vote != exp_par) p_err_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (at_vote) begin
          if (!vote) f_err_d = 1'b1;
          if (idx_q == '0) stop0_d = ~vote;
          if (last_stop) begin
            done_d      = ~is_break;
            break_det_d = is_break;
          end
        end
        if (at_end) idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase

    load         = done_q && (!dout_valid_q || dout_ready);
    overrun_d    = done_q && !load;
    dout_d       = load ? data_q  : dout_q;
    parity_err_d = load ? p_err_q : parity_err_q;
    frame_err_d  = load ? f_err_q : frame_err_q;
    if (load) begin
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      data_q       <= '0;
      par_vote_q   <= 1'b0;
      stop0_q      <= 1'b0;
      p_err_q      <= 1'b0;
      f_err_q      <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      data_q       <= data_d;
      par_vote_q   <= par_vote_d;
      stop0_q      <= stop0_d;
      p_err_q      <= p_err_d;
      f_err_q      <= f_err_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_det_q  <= break_det_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four instances cover 8N1, 8E1, 8O1 and 7O2.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int unsigned BD = 434;
  localparam int unsigned HF = 217;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] rxl;
  logic [3:0] rdy;
  wire  [3:0] dv, pe, fe, ov, bk, busy;
  wire  [7:0] d0, d1, d2;
  wire  [6:0] d3;
  wire  [7:0] dsel [4];

  assign dsel[0] = d0;
  assign dsel[1] = d1;
  assign dsel[2] = d2;
  assign dsel[3] = {1'b0, d3};

  int checks   = 0;
  int failures = 0;

  int         n_acc  [4] = '{default: 0};
  int         n_vcyc [4] = '{default: 0};
  int         n_ov   [4] = '{default: 0};
  int         n_brk  [4] = '{default: 0};
  logic [7:0] last_d [4] = '{default: 8'h00};
  logic [3:0] last_pe = '0;
  logic [3:0] last_fe = '0;

  uart_rx_param u_8n1 (
    .clk(clk), .rst(rst), .rx(rxl[0]), .dout(d0), .dout_valid(dv[0]),
    .dout_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun(ov[0]), .break_det(bk[0]), .rx_busy(busy[0]));

  uart_rx_param #(.PARITY_MODE(1)) u_8e1 (
    .clk(clk), .rst(rst), .rx(rxl[1]), .dout(d1), .dout_valid(dv[1]),
    .dout_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun(ov[1]), .break_det(bk[1]), .rx_busy(busy[1]));

  uart_rx_param #(.PARITY_MODE(2)) u_8o1 (
    .clk(clk), .rst(rst), .rx(rxl[2]), .dout(d2), .dout_valid(dv[2]),
    .dout_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun(ov[2]), .break_det(bk[2]), .rx_busy(busy[2]));

  uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .rx(rxl[3]), .dout(d3), .dout_valid(dv[3]),
    .dout_ready(rdy[3]), .parity_err(pe[3]), .frame_err(fe[3]),
    .overrun(ov[3]), .break_det(bk[3]), .rx_busy(busy[3]));

  // Scoreboard: record accepted words and count valid, overrun and break cycles.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (dv[i]) n_vcyc[i]++;
        if (ov[i]) n_ov[i]++;
        if (bk[i]) n_brk[i]++;
        if (dv[i] && rdy[i]) begin
          n_acc[i]++;
          last_d[i]  = dsel[i];
          last_pe[i] = pe[i];
          last_fe[i] = fe[i];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame bits in line order (bit 0 first): start, data LSB first, parity, stops.
  function automatic logic [15:0] frame(input logic [8:0] data, input int nd,
                                        input int np, input logic par,
                                        input logic [1:0] stops, input int ns);
    logic [15:0] f;
    int p;
    f = '1;
    p = 0;
    f[p] = 1'b0; p++;
    for (int i = 0; i < nd; i++) begin f[p] = data[i]; p++; end
    if (np != 0) begin f[p] = par; p++; end
    for (int i = 0; i < ns; i++) begin f[p] = stops[i]; p++; end
    return f;
  endfunction

  task automatic send_bits(input int ln, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxl[ln] = bits[i];
      repeat (BD) @(negedge clk);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int a0, v0, o0, b0, a1, a2, a3;
  logic [15:0] fb;

  initial begin
    rst = 1'b1;
    rxl = 4'hF;
    rdy = 4'hF;
    wait_cyc(4);
    check("rst_dout_valid", 32'(dv), 32'h0);
    check("rst_rx_busy",    32'(busy), 32'h0);
    check("rst_overrun",    32'(ov), 32'h0);
    check("rst_break",      32'(bk), 32'h0);
    check("rst_errs",       32'({pe, fe}), 32'h0);
    check("rst_dout0",      32'(d0), 32'h0);
    rst = 1'b0;
    wait_cyc(10);

    // 8N1 0xA5 with ready high
    a0 = n_acc[0]; v0 = n_vcyc[0];
    fb = frame(9'h0A5, 8, 0, 1'b0, 2'b11, 1);
    send_bits(0, fb, 4);
    check("8n1_busy_mid", 32'(busy[0]), 32'h1);
    send_bits(0, fb >> 4, 6);
    check("8n1_accepted", 32'(n_acc[0] - a0), 32'd1);
    check("8n1_dout", 32'(last_d[0]), 32'hA5);
    check("8n1_parity_err", 32'(last_pe[0]), 32'h0);
    check("8n1_frame_err", 32'(last_fe[0]), 32'h0);
    check("8n1_valid_cycles", 32'(n_vcyc[0] - v0), 32'd1);
    check("8n1_busy_end", 32'(busy[0]), 32'h0);

    // 8E1 0x3C with parity bit 1 (wrong), then 8O1 with parity 1 (correct)
    a1 = n_acc[1];
    send_bits(1, frame(9'h03C, 8, 1, 1'b1, 2'b11, 1), 11);
    check("8e1_accepted", 32'(n_acc[1] - a1), 32'd1);
    check("8e1_dout", 32'(last_d[1]), 32'h3C);
    check("8e1_parity_err", 32'(last_pe[1]), 32'h1);
    check("8e1_frame_err", 32'(last_fe[1]), 32'h0);
    a2 = n_acc[2];
    send_bits(2, frame(9'h03C, 8, 1, 1'b1, 2'b11, 1), 11);
    check("8o1_accepted", 32'(n_acc[2] - a2), 32'd1);
    check("8o1_dout", 32'(last_d[2]), 32'h3C);
    check("8o1_parity_err", 32'(last_pe[2]), 32'h0);

    // 7O2 0x55, correct odd parity, second stop bit low
    a3 = n_acc[3];
    send_bits(3, frame(9'h055, 7, 1, 1'b1, 2'b01, 2), 11);
    rxl[3] = 1'b1;
    wait_cyc(BD);
    check("7o2_accepted", 32'(n_acc[3] - a3), 32'd1);
    check("7o2_dout", 32'(last_d[3]), 32'h55);
    check("7o2_parity_err", 32'(last_pe[3]), 32'h0);
    check("7o2_frame_err", 32'(last_fe[3]), 32'h1);

    // 100-cycle glitch: false start rejected at the START vote
    v0 = n_vcyc[0];
    rxl[0] = 1'b0;
    wait_cyc(100);
    rxl[0] = 1'b1;
    wait_cyc(50);
    check("glitch_busy_during", 32'(busy[0]), 32'h1);
    wait_cyc(110);
    check("glitch_busy_after", 32'(busy[0]), 32'h0);
    wait_cyc(BD);
    check("glitch_no_valid", 32'(n_vcyc[0] - v0), 32'd0);

    // Overrun: ready low, 0x11 then 0x22 back-to-back
    rdy[0] = 1'b0;
    o0 = n_ov[0];
    send_bits(0, frame(9'h011, 8, 0, 1'b0, 2'b11, 1), 10);
    send_bits(0, frame(9'h022, 8, 0, 1'b0, 2'b11, 1), 10);
    wait_cyc(10);
    check("ovr_valid_held", 32'(dv[0]), 32'h1);
    check("ovr_dout_held", 32'(d0), 32'h11);
    check("ovr_pulses", 32'(n_ov[0] - o0), 32'd1);
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_consumed", 32'(dv[0]), 32'h0);
    check("ovr_dout_keeps", 32'(d0), 32'h11);
    wait_cyc(10);

    // Break: 12 bit times low, then a normal frame
    a0 = n_acc[0]; v0 = n_vcyc[0]; b0 = n_brk[0];
    rxl[0] = 1'b0;
    wait_cyc(12 * BD);
    check("brk_busy_wait", 32'(busy[0]), 32'h1);
    check("brk_pulses", 32'(n_brk[0] - b0), 32'd1);
    rxl[0] = 1'b1;
    wait_cyc(2 * BD);
    check("brk_no_valid", 32'(n_vcyc[0] - v0), 32'd0);
    check("brk_busy_after", 32'(busy[0]), 32'h0);
    send_bits(0, frame(9'h00F, 8, 0, 1'b0, 2'b11, 1), 10);
    check("brk_next_accepted", 32'(n_acc[0] - a0), 32'd1);
    check("brk_next_dout", 32'(last_d[0]), 32'h0F);

    // Reset in the middle of a frame, line held low through reset
    a0 = n_acc[0]; v0 = n_vcyc[0]; b0 = n_brk[0]; o0 = n_ov[0];
    send_bits(0, 16'h0000, 2);
    wait_cyc(HF);
    rst = 1'b1;
    wait_cyc(3);
    check("mid_rst_busy", 32'(busy[0]), 32'h0);
    rst = 1'b0;
    wait_cyc(20);
    check("mid_rst_low_no_start", 32'(busy[0]), 32'h0);
    rxl[0] = 1'b1;
    wait_cyc(12 * BD);
    check("mid_rst_no_valid", 32'(n_vcyc[0] - v0), 32'd0);
    check("mid_rst_no_pulse", 32'((n_ov[0] - o0) + (n_brk[0] - b0)), 32'd0);
    check("mid_rst_errs", 32'({pe[0], fe[0]}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
